// File: rtl/calc_display_driver.sv
// Converts the core's signed result to sign-magnitude BCD (24-cycle shift-add-3) and
// scans it onto an 8-digit active-low 7-segment display; no backpressure, input is re-sampled when idle.
module calc_display_driver #(
  parameter int CLK_DIV = 1000
) (
  input  logic        clk,
  input  logic        pwr,
  input  logic [31:0] displayedNum,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic [31:0] bcd
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   lat_q, lat_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;
  logic [23:0]   sreg_q, sreg_d;
  logic [27:0]   acc_q, acc_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   bcd_q, bcd_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [31:0]   mag;
  logic          mismatch;
  logic [31:0]   fmt;
  logic [27:0]   acc_adj;

  function automatic logic [6:0] seg_dec(input logic [3:0] c);
    case (c)
      4'h0: seg_dec = 7'b1000000;
      4'h1: seg_dec = 7'b1111001;
      4'h2: seg_dec = 7'b0100100;
      4'h3: seg_dec = 7'b0110000;
      4'h4: seg_dec = 7'b0011001;
      4'h5: seg_dec = 7'b0010010;
      4'h6: seg_dec = 7'b0000010;
      4'h7: seg_dec = 7'b1111000;
      4'h8: seg_dec = 7'b0000000;
      4'h9: seg_dec = 7'b0010000;
      4'hA: seg_dec = 7'b0111111;
      4'hE: seg_dec = 7'b0000110;
      default: seg_dec = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (pwr) begin
      state_q <= IDLE;
      lat_q   <= 32'd0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      sreg_q  <= 24'd0;
      acc_q   <= 28'd0;
      cnt_q   <= 5'd0;
      bcd_q   <= 32'hBBBBBBB0;
      pre_q   <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFE;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // Magnitude of the incoming value; 0x80000000 maps to 2^31 and lands in overflow.
  assign mag      = displayedNum[31] ? (~displayedNum + 32'd1) : displayedNum;
  assign mismatch = (displayedNum != lat_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mismatch) state_d = (mag > 32'd9_999_999) ? FORMAT : CONVERT;
      CONVERT: if (cnt_q == 5'd23) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 7; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Blank leading zeros above the most significant nonzero digit; sign goes one place left of it.
  always_comb begin
    int top;
    top = 0;
    fmt = 32'hBBBBBBBB;
    for (int i = 0; i < 7; i++) begin
      if (acc_q[4*i +: 4] != 4'd0) top = i;
    end
    for (int i = 0; i < 7; i++) begin
      if (i <= top) fmt[4*i +: 4] = acc_q[4*i +: 4];
    end
    for (int i = 1; i < 8; i++) begin
      if (neg_q && (i == top + 1)) fmt[4*i +: 4] = 4'hA;
    end
    if (ovf_q) fmt = 32'hBBBBBBBE;
  end

  always_comb begin
    lat_d  = lat_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    sreg_d = sreg_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    case (state_q)
      IDLE: begin
        if (mismatch) begin
          lat_d  = displayedNum;
          neg_d  = displayedNum[31];
          ovf_d  = (mag > 32'd9_999_999);
          sreg_d = mag[23:0];
          acc_d  = 28'd0;
          cnt_d  = 5'd0;
        end
      end
      CONVERT: begin
        {acc_d, sreg_d} = {acc_adj, sreg_q} << 1;
        cnt_d           = cnt_q + 5'd1;
      end
      FORMAT:  bcd_d = fmt;
      default: ;
    endcase
  end

  // Scanner is free-running; outputs are registered from next-state values so they track idx_q.
  always_comb begin
    if (pre_q == PW'(CLK_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      pre_d = pre_q + PW'(1);
      idx_d = idx_q;
    end
    an_d  = ~(8'd1 << idx_d);
    seg_d = seg_dec(bcd_d[{idx_d, 2'b00} +: 4]);
  end

  always_comb begin
    busy = (state_q != IDLE);
    dp   = 1'b1;
    bcd  = bcd_q;
    an   = an_q;
    seg  = seg_q;
  end

endmodule

// File: tb/tb_calc_display_driver.sv
// Directed + random checks of calc_display_driver against an arithmetic decimal model.
module tb_calc_display_driver;

  logic        clk = 1'b0;
  logic        pwr;
  logic [31:0] displayedNum;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic [31:0] bcd;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_lat;

  calc_display_driver #(.CLK_DIV(4)) dut (
    .clk(clk), .pwr(pwr), .displayedNum(displayedNum),
    .an(an), .seg(seg), .dp(dp), .busy(busy), .bcd(bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    longint unsigned m;
    logic [31:0] r;
    int n;
    m = v[31] ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    if (m > 64'd9_999_999) return 32'hBBBBBBBE;
    r = 32'hBBBBBBBB;
    n = 0;
    do begin
      r[4*n +: 4] = 4'(m % 10);
      m = m / 10;
      n++;
    end while (m != 0);
    if (v[31]) r[4*n +: 4] = 4'hA;
    return r;
  endfunction

  function automatic int model_busy(input logic [31:0] v);
    return (model_bcd(v) == 32'hBBBBBBBE) ? 1 : 25;
  endfunction

  function automatic logic [6:0] model_seg(input logic [3:0] c);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
            7'b1111111, 7'b1111111, 7'b0000110, 7'b1111111};
    return tab[c];
  endfunction

  task automatic run_conv(input logic [31:0] v, input string tag);
    int n;
    logic [31:0] prev;
    prev = bcd;
    @(negedge clk);
    displayedNum = v;
    step();
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      chk({tag, " hold"}, bcd, prev);
      n++;
      step();
    end
    chk({tag, " busy cycles"}, 32'(n), 32'(model_busy(v)));
    chk({tag, " bcd"}, bcd, model_bcd(v));
    cur_lat = v;
  endtask

  initial begin
    int k;
    logic [31:0] v;
    logic [31:0] exp_fmt;
    logic [7:0]  exp_an;
    logic [3:0]  nib;

    pwr = 1'b1;
    displayedNum = 32'd0;
    cur_lat = 32'd0;
    step();
    step();
    chk("reset bcd", bcd, 32'hBBBBBBB0);
    chk("reset an", {24'd0, an}, 32'h000000FE);
    chk("reset seg", {25'd0, seg}, {25'd0, 7'b1000000});
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset dp", {31'd0, dp}, 32'd1);
    @(negedge clk);
    pwr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle after reset", {31'd0, busy}, 32'd0);
    end

    run_conv(32'd8, "eight");
    run_conv(32'd16, "sixteen");
    run_conv(-32'sd6, "minus6");
    run_conv(-32'sd1234567, "minus1234567");
    run_conv(32'd9_999_999, "max");
    run_conv(32'd10_000_000, "ovf pos");
    run_conv(-32'sd10_000_000, "ovf neg");
    run_conv(32'h80000000, "ovf min");

    for (int i = 0; i < 4; i++) begin
      step();
      chk("same value idle", {31'd0, busy}, 32'd0);
    end

    // Input changes mid-conversion; the first result must stand, then a fresh one follows.
    @(negedge clk);
    displayedNum = 32'd5;
    step();
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    displayedNum = 32'd42;
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      k++;
      step();
    end
    chk("midchange first", bcd, 32'hBBBBBBB5);
    k = 0;
    while (bcd !== 32'hBBBBBB42 && k < 100) begin
      k++;
      step();
    end
    chk("midchange delay", 32'(k), 32'd26);
    chk("midchange second", bcd, 32'hBBBBBB42);
    cur_lat = 32'd42;

    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: v = 32'($urandom_range(0, 9_999_999));
        1: v = -32'($urandom_range(1, 9_999_999));
        2: v = $urandom;
        default: v = 32'($urandom_range(0, 99));
      endcase
      if (v == cur_lat) v = v + 32'd1;
      run_conv(v, "random");
    end

    @(negedge clk);
    displayedNum = 32'd777;
    for (int i = 0; i < 10; i++) step();
    chk("abort busy before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    pwr = 1'b1;
    displayedNum = 32'd0;
    step();
    chk("abort bcd", bcd, 32'hBBBBBBB0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort an", {24'd0, an}, 32'h000000FE);
    chk("abort seg", {25'd0, seg}, {25'd0, 7'b1000000});
    @(negedge clk);
    pwr = 1'b0;
    cur_lat = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle after abort", {31'd0, busy}, 32'd0);
    end

    v = -32'sd1234567;
    run_conv(v, "scan value");
    exp_fmt = model_bcd(v);
    k = 0;
    while (an === 8'hFE && k < 40) begin
      k++;
      step();
    end
    k = 0;
    while (an !== 8'hFE && k < 40) begin
      k++;
      step();
    end
    chk("scan align", {24'd0, an}, 32'h000000FE);
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'd1 << d);
      nib = exp_fmt[4*d +: 4];
      for (int c = 0; c < 4; c++) begin
        chk("scan an", {24'd0, an}, {24'd0, exp_an});
        chk("scan seg", {25'd0, seg}, {25'd0, model_seg(nib)});
        step();
      end
    end
    chk("scan wrap", {24'd0, an}, 32'h000000FE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_display_driver.md
# calc_display_driver

Output-side companion to the calculator core. It reads the core's 32-bit signed `displayedNum` result and converts it to sign-magnitude BCD with a sequential shift-add-3 engine. It then drives an 8-digit multiplexed, active-low 7-segment display. It sits between the calculator core and the board display pins, in the same clock domain as the core.

## Interface
- `CLK_DIV`, default 1000: clock cycles each digit is lit before the scanner advances; must be ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `pwr`  in  1  reset; synchronous, active-high. It is the same power-on pulse that drives the calculator core.
- `displayedNum`  in  32  two's-complement value from the calculator core.
- `an`  out  8  digit enables, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point; constant 1 (off).
- `busy`  out  1  high while a conversion is in flight.
- `bcd`  out  32  eight 4-bit display codes; `bcd[3:0]` is digit 0.
  - 0–9: digit.
  - 4'hA: minus sign.
  - 4'hB: blank.
  - 4'hE: letter E.

## Operation
- FSM states:
  - IDLE: compare `displayedNum` with the latched value `lat`. On a mismatch, set `lat <= displayedNum`, compute `neg = lat[31]` and `mag = |lat|` as 32-bit unsigned (so 0x80000000 gives 2^31).
    - If `mag > 9_999_999`, go to FORMAT with `ovf = 1`.
    - Otherwise load a 24-bit shift register with `mag[23:0]`, clear the 28-bit BCD accumulator and the iteration counter, and go to CONVERT.
  - CONVERT: one double-dabble iteration per cycle. Add 3 to every accumulator nibble ≥ 5, then shift `{acc, sreg}` left by 1. After 24 iterations, go to FORMAT.
  - FORMAT: build eight codes and write all of `bcd` in a single cycle, then go to IDLE.
- FORMAT rules:
  - `ovf = 1`: `bcd = 32'hBBBBBBBE`, regardless of sign.
  - Otherwise digits 0–6 come from the accumulator and digit 7 is blank. Leading zeros are blanked, except that digit 0 is never blanked.
  - If `neg`, put 4'hA in the digit immediately left of the most significant non-blank digit. A 7-digit magnitude puts the sign in digit 7.
- `displayedNum` changes during CONVERT or FORMAT are ignored. On return to IDLE, the mismatch with `lat` triggers a new conversion, so the display always settles to the last stable input.
- `bcd` never holds a partial result; it is written only in FORMAT.
- Scanner runs free and independently of the FSM.
  - Prescaler counts 0..CLK_DIV-1. On wrap, the digit index increments 0..7, wrapping 7 → 0.
  - `an = ~(8'b1 << idx)`.
  - `seg` = decode of `bcd[idx]`: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0111111, E:0000110. B, C, D and F decode to 1111111.
- `an` and `seg` are registered outputs.

## Timing
- Reset values: state IDLE, `lat = 0`, `bcd = 32'hBBBBBBB0`, `busy = 0`, prescaler 0, `idx = 0`, `an = 8'hFE`, `seg = 7'b1000000`, `dp = 1`.
- Normal conversion, with the mismatch seen at edge E0:
  - Iterations happen at E1..E24.
  - `bcd` is updated at E25.
  - `busy` is high from E0+ through E25 (25 cycles).
- Overflow: `bcd` is updated at E1, and `busy` is high for 1 cycle.
- `pwr` asserted in any state, including mid-CONVERT, forces all reset values at the next edge. It aborts the conversion with no `bcd` write.
- A `displayedNum` equal to `lat` never starts a conversion; 0 after reset is idle.
- Each digit is held exactly CLK_DIV cycles. A full refresh takes 8×CLK_DIV cycles.

## Test plan
- Reset with `pwr` = 1 for 2 cycles and `displayedNum` = 0 → `bcd` = BBBBBBB0, `an` = FE, `seg` = 1000000, `busy` = 0, and no conversion after release.
- `displayedNum` = 8 → `busy` high for 25 cycles, then `bcd` = BBBBBBB8. Then 16 → BBBBBB16.
- −6 (0xFFFFFFFA) → BBBBBBA6. −1234567 → A1234567. 9_999_999 → B9999999.
- 10_000_000, −10_000_000 and 0x80000000 → each BBBBBBBE one cycle after the change, with `busy` high for 1 cycle.
- Change 5 → 42 at the 10th CONVERT cycle → `bcd` = BBBBBBB5 at completion, then BBBBBB42 26 cycles later. Assert `pwr` mid-conversion → reset values next cycle.
- `CLK_DIV` = 4, `bcd` = A1234567 → `an` walks FE, FD, FB, F7, EF, DF, BF, 7F with 4 cycles each and wraps. `seg` matches 7, 6, 5, 4, 3, 2, 1, minus in that order.
